// File: rtl/onewire_slave_rx.sv
// onewire_slave_rx
// Receive-side 1-Wire bit decoder. Measures each low pulse on the bus,
// classifies it as a 1 (short), a 0 (long) or an error, and assembles
// decoded bits LSB-first into bytes.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-low reset
//   bus_in     bus level (1 = released, 0 = pulled low)
//   bit_out    decoded bit value, valid with bit_valid
//   bit_valid  one-cycle strobe per decoded bit
//   byte_out   last completed byte (LSB = first bit), held between updates
//   byte_valid one-cycle strobe when a byte completes (with bit_valid)
//   frame_err  one-cycle strobe on pulse-width violation or timeout
//   busy       high while a low pulse is being measured
//
// Handshake: all strobes are push-only, one cycle wide, with no ready/
// backpressure; the consumer must capture them in the cycle they are high.
module onewire_slave_rx #(
  parameter int ONE_MIN  = 3,
  parameter int ONE_MAX  = 15,
  parameter int ZERO_MIN = 40,
  parameter int ZERO_MAX = 80,
  parameter int CNT_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_in,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {ARM, IDLE, LOW, HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE_MIN_C  = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] ONE_MAX_C  = CNT_W'(ONE_MAX);
  localparam logic [CNT_W-1:0] ZERO_MIN_C = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] ZERO_MAX_C = CNT_W'(ZERO_MAX);

  state_t           state;
  logic             s;      // registered bus level
  logic             s_ok;   // s holds a real bus sample (not the reset value)
  logic [CNT_W-1:0] cnt;    // sampled low cycles of the current pulse
  logic [2:0]       idx;    // next bit position in the byte
  logic [7:0]       shift;  // partial byte under assembly

  logic is_one;
  logic is_zero;

  assign is_one  = (cnt >= ONE_MIN_C)  && (cnt <= ONE_MAX_C);
  assign is_zero = (cnt >= ZERO_MIN_C) && (cnt <= ZERO_MAX_C);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARM;
      s          <= 1'b1;
      s_ok       <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      s          <= bus_in;
      s_ok       <= 1'b1;
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        // s_ok keeps the reset value of s from arming us while the bus is
        // still held low, so a low present at reset release is never measured.
        ARM: begin
          if (s_ok && s) state <= IDLE;
        end
        IDLE: begin
          if (!s) begin
            state <= LOW;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        LOW: begin
          if (!s) begin
            if (cnt == ZERO_MAX_C) begin
              // Timeout: report once, drop the partial byte, wait for release.
              frame_err <= 1'b1;
              idx       <= '0;
              cnt       <= '0;
              busy      <= 1'b0;
              state     <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            if (is_one || is_zero) begin
              bit_out    <= is_one;
              bit_valid  <= 1'b1;
              shift[idx] <= is_one;
              if (idx == 3'd7) begin
                byte_out   <= {is_one, shift[6:0]};
                byte_valid <= 1'b1;
              end
              idx <= idx + 3'd1;  // wraps to 0 after the 8th bit
            end else begin
              frame_err <= 1'b1;
              idx       <= '0;
            end
          end
        end
        HOLD: begin
          if (s) state <= IDLE;
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_slave_rx.sv
// Self-checking bench for onewire_slave_rx: scenario tasks drive pulses and
// push expected bits/bytes/errors into queues; a monitor pops and compares
// whenever the DUT strobes.
module tb_onewire_slave_rx;

  logic       clk;
  logic       rst;
  logic       bus_in;
  logic       bit_out;
  logic       bit_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_bit_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_err;
  logic [7:0] exp_hold;   // value byte_out must hold
  int         m_idx;      // model bit index
  logic [7:0] m_byte;     // model partial byte

  onewire_slave_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_bit_q.delete();
    exp_byte_q.delete();
    exp_err  = 0;
    exp_hold = 8'h00;
    m_idx    = 0;
    m_byte   = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- model / drivers ----------------
  // 0 = bit 0, 1 = bit 1, 2 = error (glitch, out-of-range width or timeout)
  function automatic int classify(input int w);
    if (w >= 3 && w <= 15) return 1;
    if (w >= 40 && w <= 80) return 0;
    return 2;
  endfunction

  task automatic expect_pulse(input int w);
    int c;
    c = classify(w);
    if (c == 2) begin
      exp_err = exp_err + 1;
      m_idx   = 0;
    end else begin
      exp_bit_q.push_back(1'(c));
      m_byte[m_idx] = 1'(c);
      m_idx = m_idx + 1;
      if (m_idx == 8) begin
        exp_byte_q.push_back(m_byte);
        m_idx = 0;
      end
    end
  endtask

  // Bus low for exactly w sampling edges; returns at the negedge of the rise.
  task automatic drive_low(input int w);
    @(negedge clk);
    bus_in = 1'b0;
    repeat (w) @(negedge clk);
    bus_in = 1'b1;
  endtask

  task automatic send_pulse(input int w, input int gap);
    expect_pulse(w);
    drive_low(w);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) send_pulse(b[i] ? 6 : 60, gap);
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(posedge clk);
    #1;
    if (bit_valid || frame_err) begin
      n_checks++;
      if (bit_valid && frame_err) begin
        n_fail++;
        $display("FAIL strobe_excl: got bit_valid=1 frame_err=1, required not both");
      end
    end
    if (bit_valid) begin
      n_checks++;
      if (exp_bit_q.size() == 0) begin
        n_fail++;
        $display("FAIL bit_unexpected: got bit %0b, required no bit_valid", bit_out);
      end else begin
        logic [0:0] e;
        e = exp_bit_q.pop_front();
        if (bit_out !== e) begin
          n_fail++;
          $display("FAIL bit_value: got %0b, required %0b", bit_out, e);
        end
      end
    end
    if (byte_valid) begin
      n_checks++;
      if (!bit_valid) begin
        n_fail++;
        $display("FAIL byte_with_bit: got bit_valid=0 with byte_valid, required 1");
      end
      if (exp_byte_q.size() == 0) begin
        n_fail++;
        $display("FAIL byte_unexpected: got %02h, required no byte_valid", byte_out);
      end else begin
        exp_hold = exp_byte_q.pop_front();
        if (byte_out !== exp_hold) begin
          n_fail++;
          $display("FAIL byte_value: got %02h, required %02h", byte_out, exp_hold);
        end
      end
    end else if (bit_valid || frame_err) begin
      n_checks++;
      if (byte_out !== exp_hold) begin
        n_fail++;
        $display("FAIL byte_hold: got %02h, required %02h", byte_out, exp_hold);
      end
    end
    if (frame_err) begin
      n_checks++;
      if (exp_err == 0) begin
        n_fail++;
        $display("FAIL err_unexpected: got frame_err=1, required 0");
      end else begin
        exp_err = exp_err - 1;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus_in = 1'b0;  // low during reset must not disturb reset values
    apply_reset();
    n_checks++;
    if ({bit_out, bit_valid, byte_out, byte_valid, frame_err, busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %04h, required 0000",
               {bit_out, bit_valid, byte_out, byte_valid, frame_err, busy});
    end
    bus_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_byte_a5();
    apply_reset();
    send_byte(8'hA5, 1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_bit_q.size() != 0 || exp_byte_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL a5_drain: got %0d/%0d/%0d pending, required 0/0/0",
               exp_bit_q.size(), exp_byte_q.size(), exp_err);
    end
  endtask

  task automatic test_widths();
    int widths[7] = '{2, 3, 15, 16, 39, 40, 80};
    logic [2:0] want[7] = '{3'b001, 3'b110, 3'b110, 3'b001, 3'b001, 3'b100, 3'b100};
    for (int k = 0; k < 7; k++) begin
      apply_reset();
      expect_pulse(widths[k]);
      drive_low(widths[k]);
      @(negedge clk);
      n_checks++;
      if ({bit_valid, frame_err, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL width%0d_early: got v/e/busy=%03b, required 001",
                 widths[k], {bit_valid, frame_err, busy});
      end
      @(negedge clk);
      n_checks++;
      if ({bit_valid, bit_out, frame_err} !== want[k] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL width%0d_strobe: got v/b/e=%03b busy=%0b, required %03b busy=0",
                 widths[k], {bit_valid, bit_out, frame_err}, busy, want[k]);
      end
      @(negedge clk);
      n_checks++;
      if ({bit_valid, frame_err} !== 2'b00) begin
        n_fail++;
        $display("FAIL width%0d_oneshot: got v/e=%02b, required 00",
                 widths[k], {bit_valid, frame_err});
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    int at;
    apply_reset();
    send_pulse(6, 2);
    send_pulse(6, 2);
    send_pulse(60, 2);
    exp_err = exp_err + 1;
    m_idx   = 0;
    seen    = 0;
    at      = 0;
    @(negedge clk);
    bus_in = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_err) begin
        seen++;
        at = i;
      end
    end
    n_checks++;
    if (seen != 1 || at != 82) begin
      n_fail++;
      $display("FAIL timeout_err: got %0d strobes at cycle %0d, required 1 at 82", seen, at);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: got %0b, required 0", busy);
    end
    bus_in = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h3C, 1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_bit_q.size() != 0 || exp_byte_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL timeout_drain: got %0d/%0d/%0d pending, required 0/0/0",
               exp_bit_q.size(), exp_byte_q.size(), exp_err);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] pat;
    int strobes;
    pat = 8'h6B;
    apply_reset();
    send_pulse(60, 2);  // leave the model at bit index 1 before the reset
    @(negedge clk);
    bus_in = 1'b0;
    repeat (30) @(negedge clk);
    apply_reset();      // bus still low across and after release
    strobes = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (bit_valid || frame_err || byte_valid || busy) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %0d active cycles, required 0", strobes);
    end
    bus_in = 1'b1;
    repeat (3) @(negedge clk);
    send_pulse(6, 2);
    n_checks++;
    if (byte_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_byte0: got %02h, required 00", byte_out);
    end
    for (int i = 1; i < 8; i++) send_pulse(pat[i] ? 6 : 60, 1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (byte_out !== 8'h6B) begin
      n_fail++;
      $display("FAIL midrst_byte: got %02h, required 6b", byte_out);
    end
    n_checks++;
    if (exp_bit_q.size() != 0 || exp_byte_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL midrst_drain: got %0d/%0d/%0d pending, required 0/0/0",
               exp_bit_q.size(), exp_byte_q.size(), exp_err);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_byte(8'hFF, 1);
    send_byte(8'h00, 1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (byte_out !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_last: got %02h, required 00", byte_out);
    end
    n_checks++;
    if (exp_bit_q.size() != 0 || exp_byte_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d/%0d/%0d pending, required 0/0/0",
               exp_bit_q.size(), exp_byte_q.size(), exp_err);
    end
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    w = $urandom_range(1, 2);
        2, 3, 4: w = $urandom_range(3, 15);
        default: w = $urandom_range(40, 80);
      endcase
      send_pulse(w, $urandom_range(1, 3));
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_bit_q.size() != 0 || exp_byte_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d/%0d/%0d pending, required 0/0/0",
               exp_bit_q.size(), exp_byte_q.size(), exp_err);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst      = 1'b0;
    bus_in   = 1'b1;
    exp_err  = 0;
    exp_hold = 8'h00;
    m_idx    = 0;
    m_byte   = 8'h00;
    test_reset();
    test_byte_a5();
    test_widths();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onewire_slave_rx.md
Name: onewire_slave_rx

Overview:
- Receive-side bit decoder for the 1-Wire link. It sits directly downstream of the master transmitter and samples the open-drain bus.
- The master signals a bit by pulling the bus low: a 1 is a low pulse of ~6 cycles, a 0 is a low pulse of ~60 cycles.
- This block measures each low-pulse width, classifies it as 1, 0 or error, and assembles bits LSB-first into bytes.
- It presents each decoded bit and each completed byte as single-cycle strobes.

Parameters:
- ONE_MIN, 3: minimum low width (cycles) accepted as a 1.
- ONE_MAX, 15: maximum low width accepted as a 1.
- ZERO_MIN, 40: minimum low width accepted as a 0.
- ZERO_MAX, 80: maximum low width accepted as a 0; exceeding it is a timeout.
- CNT_W, 7: width counter bits; must satisfy 2^CNT_W > ZERO_MAX+1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- bus_in  input  1  1-Wire bus level (1 = released/high, 0 = pulled low).
- bit_out  output  1  decoded bit value; valid when bit_valid=1.
- bit_valid  output  1  one-cycle strobe per correctly decoded bit.
- byte_out  output  8  assembled byte, LSB = first bit received; holds its value between updates.
- byte_valid  output  1  one-cycle strobe when the 8th bit completes a byte.
- frame_err  output  1  one-cycle strobe on a pulse-width violation or timeout.
- busy  output  1  high while a low pulse is being measured (state LOW).

Behaviour:
- Input sampling:
  - bus_in is registered once into s; s resets to 1.
  - All decisions use s, never bus_in directly.
- Reset (rst=0 at a posedge):
  - state=ARM, width counter=0, bit index=0.
  - bit_out=0, bit_valid=0, byte_out=8'h00, byte_valid=0, frame_err=0, busy=0, s=1.
  - Reset has priority over all other events, including a pulse in progress.
- States:
  - ARM: wait for s=1, then go to IDLE. A low present at reset release is never measured. No strobes in ARM.
  - IDLE: on s=0, go to LOW with counter=1. Otherwise stay.
  - LOW: busy=1.
    - While s=0: counter increments. When counter would exceed ZERO_MAX, pulse frame_err next cycle, clear bit index, go to HOLD.
    - On s=1: classify counter L and go to IDLE.
  - HOLD: ignore the bus until s=1, then go to IDLE. No further strobes for that pulse.
- Classification (at the LOW→IDLE transition; outputs registered, so strobes appear the following cycle):
  - ONE_MIN ≤ L ≤ ONE_MAX: bit_out=1, bit_valid=1.
  - ZERO_MIN ≤ L ≤ ZERO_MAX: bit_out=0, bit_valid=1.
  - Any other L: frame_err=1, bit_valid=0, bit index cleared, partial byte discarded.
- Latency:
  - The first high sample is registered into s one edge after bus_in rises.
  - The strobe is registered at the next edge.
  - bit_valid is therefore high in the cycle after the second posedge following the bus rise.
- Byte assembly:
  - Each valid bit is written into byte position [bit index]; bit index then increments.
  - On the 8th bit (index 7): byte_out is updated with the full byte in the same cycle bit_valid and byte_valid assert, and the index wraps to 0.
  - byte_out changes only on byte_valid or reset.
- Gaps: a single high sample between pulses is sufficient. Back-to-back pulses are decoded with no lost bit.
- Counter:
  - Never wraps: timeout triggers at ZERO_MAX+1 before overflow.
  - The counter is cleared on entry to IDLE or HOLD.
- Strobe exclusivity: bit_valid and frame_err are never high in the same cycle. byte_valid implies bit_valid.

Test Plan:
- Reset, then 8 master-format pulses (6 low/1 high for a 1, 60 low/1 high for a 0) encoding 0xA5 LSB-first → 8 bit_valid strobes with bit_out 1,0,1,0,0,1,0,1; byte_valid once with byte_out=8'hA5 coincident with the 8th bit_valid; frame_err never asserted.
- Single pulses of width 2,3,15,16,39,40,80 with resets between → frame_err, 1, 1, frame_err, frame_err, 0, 0 respectively; each strobe exactly one cycle, two posedges after the bus rise.
- Bus held low 100 cycles after 3 valid bits → frame_err pulses once, at 81 sampled low cycles; busy drops; no bit_valid at release. A following full byte 0x3C decodes correctly, proving the partial byte was discarded.
- Assert rst for 2 cycles mid-way through a 60-cycle low, bus still low after release → no outputs until bus goes high. The next complete 1-pulse produces bit_valid with bit index 0; byte_out=8'h00 until the first full byte.
- Two bytes 0xFF then 0x00 with a 1-cycle high gap between every pulse → 16 bit_valid strobes, two byte_valid strobes with 8'hFF then 8'h00, no frame_err.
- Random mix of valid pulses and 1-cycle glitches → every glitch gives frame_err and restarts byte assembly; scoreboard matches all bytes completed after the last error.
